// File: rtl/vme_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vme_master_pkg
// Brief    : Shared state encoding and command/result bit positions for the
//            A24/D16 VME cycle master.
// Revision : 1.0 - initial release
// ============================================================================
package vme_master_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETUP     = 3'd1,
        STROBE    = 3'd2,
        WAIT_ACK  = 3'd3,
        RELEASE   = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    localparam int CMD_WR_BIT   = 24;
    localparam int CMD_RD_BIT   = 25;
    localparam int RES_BERR_BIT = 16;
    localparam int RES_TMO_BIT  = 17;

    // A24 non-privileged data access
    localparam logic [5:0] AM_A24_DATA = 6'h39;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage : vme_master_pkg
`default_nettype wire

// File: rtl/vme_sync2.sv
`default_nettype none
// ============================================================================
// Module   : vme_sync2
// Brief    : Two-flop synchronizer of parameterized width with a reset value.
// Revision : 1.0 - initial release
// ============================================================================
module vme_sync2 #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule : vme_sync2
`default_nettype wire

// File: rtl/vme_cycle_master.sv
`default_nettype none
// ============================================================================
// Module   : vme_cycle_master
// Brief    : Runs one A24/D16 VME data-transfer cycle per accepted command and
//            returns read data or bus-error/timeout status.
// Revision : 1.0 - initial release
// ============================================================================
module vme_cycle_master
    import vme_master_pkg::*;
#(
    parameter logic [5:0]  AM_CODE     = AM_A24_DATA,
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] vme_cmd_reg,
    input  logic [31:0] vme_dat_reg_in,
    output logic        vme_cmd_rd,
    output logic        vme_dat_wr,
    output logic [31:0] vme_dat_reg_out,
    output logic [22:0] vme_addr,
    output logic [5:0]  vme_am,
    output logic        vme_as_b,
    output logic [1:0]  vme_ds_b,
    output logic        vme_write_b,
    output logic [15:0] vme_data_out,
    output logic        vme_data_oe,
    input  logic [15:0] vme_data_in,
    input  logic        vme_dtack_b,
    input  logic        vme_berr_b
);

    localparam logic [3:0]  c_setup_load = 4'(SETUP_CYC - 1);
    localparam logic [15:0] c_tmo_limit  = 16'(TIMEOUT_CYC);
    localparam logic [31:0] c_res_berr   = 32'h1 << RES_BERR_BIT;
    localparam logic [31:0] c_res_tmo    = 32'h1 << RES_TMO_BIT;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_armed;
    logic [3:0]  r_setup_cnt;
    logic [15:0] r_tmo_cnt;
    logic [15:0] w_tmo_inc;
    logic        w_tmo_hit;
    logic        r_write;
    logic [22:0] r_addr;
    logic [5:0]  r_am;
    logic [15:0] r_wdata;
    logic [31:0] r_result;
    logic [1:0]  w_sync_q;
    logic        w_dtk;
    logic        w_berr;
    logic        w_is_rd;
    logic        w_is_wr;
    logic        w_accept;
    logic        w_unused_bits;

    vme_sync2 #(
        .WIDTH     (2),
        .RESET_VAL (2'b11)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({vme_dtack_b, vme_berr_b}),
        .q   (w_sync_q)
    );

    assign w_dtk    = w_sync_q[1];
    assign w_berr   = w_sync_q[0];
    assign w_is_rd  = vme_cmd_reg[CMD_RD_BIT];
    assign w_is_wr  = vme_cmd_reg[CMD_WR_BIT];
    // Commands with neither direction bit are consumed without a bus cycle
    assign w_accept = start && vme_cmd_rd && (w_is_rd || w_is_wr);

    // One counter serves both the acknowledge wait and the release wait
    assign w_tmo_inc = sat_inc16(r_tmo_cnt);
    assign w_tmo_hit = (w_tmo_inc >= c_tmo_limit);

    assign w_unused_bits = ^{vme_cmd_reg[31:26], vme_cmd_reg[0], vme_dat_reg_in[31:16]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_armed <= 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:      if (w_accept) w_state_next = SETUP;
            SETUP:     if (r_setup_cnt == 4'd0) w_state_next = STROBE;
            STROBE:    w_state_next = WAIT_ACK;
            WAIT_ACK:  if (!w_dtk || !w_berr || w_tmo_hit) w_state_next = RELEASE;
            RELEASE:   w_state_next = WAIT_IDLE;
            WAIT_IDLE: if ((w_dtk && w_berr) || w_tmo_hit) w_state_next = IDLE;
            default:   w_state_next = IDLE;
        endcase
    end

    always_comb begin
        vme_cmd_rd  = 1'b0;
        vme_dat_wr  = 1'b0;
        vme_as_b    = 1'b1;
        vme_ds_b    = 2'b11;
        vme_write_b = 1'b1;
        vme_data_oe = 1'b0;
        case (r_state)
            IDLE: vme_cmd_rd = r_armed;
            SETUP: begin
                vme_write_b = !r_write;
                vme_data_oe = r_write;
            end
            STROBE: begin
                vme_as_b    = 1'b0;
                vme_write_b = !r_write;
                vme_data_oe = r_write;
            end
            WAIT_ACK: begin
                vme_as_b    = 1'b0;
                vme_ds_b    = 2'b00;
                vme_write_b = !r_write;
                vme_data_oe = r_write;
            end
            // WRITE stays valid until the slave has seen DS rise
            RELEASE: begin
                vme_dat_wr  = 1'b1;
                vme_write_b = !r_write;
            end
            WAIT_IDLE: vme_write_b = !r_write;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_am        <= '0;
            r_wdata     <= '0;
            r_write     <= 1'b0;
            r_setup_cnt <= '0;
            r_tmo_cnt   <= '0;
            r_result    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr      <= vme_cmd_reg[23:1];
                        r_am        <= AM_CODE;
                        r_wdata     <= vme_dat_reg_in[15:0];
                        r_write     <= !w_is_rd;
                        r_setup_cnt <= c_setup_load;
                    end
                end
                SETUP: begin
                    if (r_setup_cnt != 4'd0) r_setup_cnt <= r_setup_cnt - 4'd1;
                end
                STROBE: r_tmo_cnt <= '0;
                WAIT_ACK: begin
                    r_tmo_cnt <= w_tmo_inc;
                    if (!w_dtk) begin
                        r_result <= {16'h0000, (r_write ? r_wdata : vme_data_in)};
                    end else if (!w_berr) begin
                        r_result <= c_res_berr;
                    end else if (w_tmo_hit) begin
                        r_result <= c_res_tmo;
                    end
                end
                RELEASE:   r_tmo_cnt <= '0;
                WAIT_IDLE: r_tmo_cnt <= w_tmo_inc;
                default: ;
            endcase
        end
    end

    assign vme_addr        = r_addr;
    assign vme_am          = r_am;
    assign vme_data_out    = r_wdata;
    assign vme_dat_reg_out = r_result;

endmodule : vme_cycle_master
`default_nettype wire

// File: tb/tb_vme_cycle_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_vme_cycle_master
// Brief    : Self-checking bench with a behavioural VME slave and result model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vme_cycle_master;

    localparam int SETUP_CYC   = 2;
    localparam int TIMEOUT_CYC = 16;
    localparam int M_DTACK = 0, M_BERR = 1, M_BOTH = 2, M_NONE = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] vme_cmd_reg = '0;
    logic [31:0] vme_dat_reg_in = '0;
    logic        vme_cmd_rd;
    logic        vme_dat_wr;
    logic [31:0] vme_dat_reg_out;
    logic [22:0] vme_addr;
    logic [5:0]  vme_am;
    logic        vme_as_b;
    logic [1:0]  vme_ds_b;
    logic        vme_write_b;
    logic [15:0] vme_data_out;
    logic        vme_data_oe;
    logic [15:0] vme_data_in = '0;
    logic        vme_dtack_b = 1'b1;
    logic        vme_berr_b = 1'b1;

    int slv_mode = M_DTACK;
    int slv_delay = 0;
    int slv_cnt = 0;
    int errors = 0;
    int checks = 0;

    vme_cycle_master #(
        .AM_CODE     (6'h39),
        .SETUP_CYC   (SETUP_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .vme_cmd_reg     (vme_cmd_reg),
        .vme_dat_reg_in  (vme_dat_reg_in),
        .vme_cmd_rd      (vme_cmd_rd),
        .vme_dat_wr      (vme_dat_wr),
        .vme_dat_reg_out (vme_dat_reg_out),
        .vme_addr        (vme_addr),
        .vme_am          (vme_am),
        .vme_as_b        (vme_as_b),
        .vme_ds_b        (vme_ds_b),
        .vme_write_b     (vme_write_b),
        .vme_data_out    (vme_data_out),
        .vme_data_oe     (vme_data_oe),
        .vme_data_in     (vme_data_in),
        .vme_dtack_b     (vme_dtack_b),
        .vme_berr_b      (vme_berr_b)
    );

    always #5 clk = ~clk;

    // Slave answers slv_delay clocks after it first sees DS low, releases when DS rises
    always @(negedge clk) begin
        if (vme_ds_b == 2'b00) begin
            if (slv_cnt >= slv_delay) begin
                vme_dtack_b = !(slv_mode == M_DTACK || slv_mode == M_BOTH);
                vme_berr_b  = !(slv_mode == M_BERR  || slv_mode == M_BOTH);
            end
            slv_cnt++;
        end else begin
            slv_cnt     = 0;
            vme_dtack_b = 1'b1;
            vme_berr_b  = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_cycle(input logic [31:0] cmd);
        return cmd[25] || cmd[24];
    endfunction

    function automatic bit is_write(input logic [31:0] cmd);
        return !cmd[25] && cmd[24];
    endfunction

    function automatic logic [31:0] model_result(input logic [31:0] cmd, input logic [31:0] wdat,
                                                 input logic [15:0] rdat, input int mode);
        logic [15:0] d;
        d = cmd[25] ? rdat : wdat[15:0];
        case (mode)
            M_DTACK, M_BOTH: return {16'h0000, d};
            M_BERR:          return 32'h0001_0000;
            default:         return 32'h0002_0000;
        endcase
    endfunction

    // Called on a negedge; returns on the negedge after the accepting edge
    task automatic issue(input logic [31:0] cmd, input logic [31:0] wdat);
        int n = 0;
        while (vme_cmd_rd !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("cmd_rd_ready", 32'(vme_cmd_rd), 32'd1);
        vme_cmd_reg    = cmd;
        vme_dat_reg_in = wdat;
        start          = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // lat counts clocks inclusively from the accepting edge to the result pulse
    task automatic run_cmd(input logic [31:0] cmd, input logic [31:0] wdat, input logic [15:0] rdat,
                           input int mode, input int delay, output int lat, output int ds_lat);
        logic [22:0] a = '0;
        logic [5:0]  am = '0;
        logic        wb = 1'b1;
        logic [15:0] dout = '0;
        bit          as_seen = 0;
        bit          oe_seen = 0;
        int          ds_at = -1;
        int          bound;
        int          n = 0;
        logic [31:0] exp;
        slv_mode    = mode;
        slv_delay   = delay;
        vme_data_in = rdat;
        exp         = model_result(cmd, wdat, rdat, mode);
        bound       = is_cycle(cmd) ? 200 : 20;
        issue(cmd, wdat);
        check("cmd_rd_after_start", 32'(vme_cmd_rd), 32'(!is_cycle(cmd)));
        lat = 1;
        while (vme_dat_wr !== 1'b1 && lat < bound) begin
            if (vme_as_b === 1'b0) begin
                as_seen = 1;
                a    = vme_addr;
                am   = vme_am;
                wb   = vme_write_b;
                dout = vme_data_out;
            end
            if (vme_data_oe === 1'b1) oe_seen = 1;
            if (vme_ds_b === 2'b00 && ds_at < 0) ds_at = lat;
            @(negedge clk);
            lat++;
        end
        ds_lat = lat - ds_at;
        if (is_cycle(cmd)) begin
            check("dat_wr_seen", 32'(vme_dat_wr), 32'd1);
            check("result", vme_dat_reg_out, exp);
            check("addr", 32'(a), 32'(cmd[23:1]));
            check("am", 32'(am), 32'h39);
            check("write_b", 32'(wb), 32'(!is_write(cmd)));
            check("data_oe", 32'(oe_seen), 32'(is_write(cmd)));
            if (is_write(cmd)) check("data_out", 32'(dout), 32'(wdat[15:0]));
            check("strobes_released", 32'({vme_as_b, vme_ds_b, vme_data_oe}), 32'b1110);
            @(negedge clk);
            check("dat_wr_one_clock", 32'(vme_dat_wr), 32'd0);
            check("result_held", vme_dat_reg_out, exp);
            n = 0;
            while (vme_cmd_rd !== 1'b1 && n < 60) begin
                @(negedge clk);
                n++;
            end
            check("cmd_rd_return", 32'(vme_cmd_rd), 32'd1);
            check("slave_released_first", 32'({vme_dtack_b, vme_berr_b}), 32'b11);
        end else begin
            check("dropped_no_as", 32'(as_seen), 32'd0);
            check("dropped_no_dat_wr", 32'(vme_dat_wr), 32'd0);
            check("dropped_cmd_rd", 32'(vme_cmd_rd), 32'd1);
        end
    endtask

    initial begin
        int          lat;
        int          ds_lat;
        int          n;
        int          as_cnt;
        logic [31:0] cmd;
        logic [31:0] wdat;
        logic [15:0] rdat;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ctrl", 32'({vme_cmd_rd, vme_dat_wr, vme_as_b, vme_ds_b, vme_write_b, vme_data_oe}),
              32'b0011110);
        check("rst_result", vme_dat_reg_out, 32'h0);
        check("rst_addr_am_data", {3'b0, vme_addr, vme_am} | 32'(vme_data_out), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("cmd_rd_after_rst", 32'(vme_cmd_rd), 32'd1);

        // Directed write: DTACK 3 clocks after DS
        run_cmd(32'h01A8_4020, 32'h0000_BEEF, 16'h0000, M_DTACK, 3, lat, ds_lat);
        check("write_result_literal", vme_dat_reg_out, 32'h0000_BEEF);

        // Directed read
        run_cmd(32'h02A8_100C, 32'h0000_5555, 16'h1234, M_DTACK, 1, lat, ds_lat);
        check("read_result_literal", vme_dat_reg_out, 32'h0000_1234);

        // Minimum latency with a slave answering in the DS clock
        run_cmd(32'h0200_0100, 32'h0, 16'hA5A5, M_DTACK, 0, lat, ds_lat);
        check("min_latency", 32'(lat), 32'(SETUP_CYC + 5));

        // Timeout with no answer
        run_cmd(32'h0212_3456, 32'h0, 16'hFFFF, M_NONE, 0, lat, ds_lat);
        check("timeout_ds_to_wr", 32'(ds_lat), 32'(TIMEOUT_CYC));
        check("timeout_result_literal", vme_dat_reg_out, 32'h0002_0000);

        // Bus error, then BERR together with DTACK
        run_cmd(32'h0100_0200, 32'h0000_1111, 16'h0, M_BERR, 2, lat, ds_lat);
        check("berr_result_literal", vme_dat_reg_out, 32'h0001_0000);
        run_cmd(32'h0200_0300, 32'h0, 16'h7E57, M_BOTH, 2, lat, ds_lat);
        check("berr_dtack_result", vme_dat_reg_out, 32'h0000_7E57);

        // Command without a direction bit
        run_cmd(32'h00A8_0000, 32'h0000_2222, 16'h0, M_DTACK, 0, lat, ds_lat);

        // Start while busy is ignored
        slv_mode = M_DTACK;
        slv_delay = 4;
        vme_data_in = 16'hC0DE;
        issue(32'h0200_0400, 32'h0);
        vme_cmd_reg = 32'h0100_0800;
        vme_dat_reg_in = 32'h0000_DEAD;
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        n = 0;
        while (vme_dat_wr !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("busy_first_result", vme_dat_reg_out, 32'h0000_C0DE);
        n = 0;
        while (vme_cmd_rd !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        as_cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (vme_as_b === 1'b0 || vme_dat_wr === 1'b1) as_cnt++;
        end
        check("busy_start_ignored", 32'(as_cnt), 32'd0);

        // Reset while waiting for acknowledge
        slv_mode = M_NONE;
        issue(32'h0200_0500, 32'h0);
        n = 0;
        while (vme_ds_b !== 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_strobes", 32'({vme_as_b, vme_ds_b, vme_data_oe, vme_cmd_rd}), 32'b11100);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_cmd_rd", 32'(vme_cmd_rd), 32'd1);

        // Back-to-back alternating write/read
        for (int i = 0; i < 4; i++) begin
            cmd  = ($urandom & 32'h00FF_FFFE) | ((i % 2 == 0) ? 32'h0100_0000 : 32'h0200_0000);
            wdat = $urandom;
            rdat = 16'($urandom);
            run_cmd(cmd, wdat, rdat, M_DTACK, int'($urandom_range(0, 3)), lat, ds_lat);
        end

        // Random commands, slave behaviours and delays
        for (int i = 0; i < 12; i++) begin
            cmd = $urandom;
            if ($urandom_range(0, 5) == 0) cmd[25:24] = 2'b00;
            wdat = $urandom;
            rdat = 16'($urandom);
            run_cmd(cmd, wdat, rdat, int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), lat, ds_lat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_vme_cycle_master
`default_nettype wire
